// File: rtl/iob_eth_defs.sv
// Shared constants and types for the iob_eth MII datapath (RX and TX).
package iob_eth_defs;

  localparam logic [3:0]  PREAMBLE_NIB  = 4'h5;
  localparam logic [3:0]  SFD_NIB       = 4'hD;
  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [7:0]  BCAST_BYTE    = 8'hFF;
  localparam int          MIN_FRAME_DEF = 64;
  localparam int          MAC_BYTES     = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_DATA,
    ST_DONE,
    ST_DROP
  } rx_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

endpackage

// File: rtl/iob_eth_crc32.sv
// Byte-wide next-state function of the reflected Ethernet CRC-32 register.
module iob_eth_crc32
  import iob_eth_defs::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;

  // Eight LSB-first shift steps; the byte is folded into the low bits up front.
  always_comb begin
    crc_work = crc_in ^ {24'h000000, data};
    for (int i = 0; i < 8; i++) begin
      crc_work = crc_work[0] ? ((crc_work >> 1) ^ CRC_POLY) : (crc_work >> 1);
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/iob_eth_rx_mii.sv
// MII receive front end: preamble/SFD strip, nibble assembly, MAC filter,
// buffer write and CRC-32 check, with a ready/ack report to the CPU side.
module iob_eth_rx_mii
  import iob_eth_defs::*;
#(
  parameter int BUF_ADDR_W = 11,
  parameter int MIN_FRAME  = MIN_FRAME_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            rx_data,
  input  logic                  rx_dv,
  input  logic [47:0]           mac_addr,
  input  logic                  rcv_ack,
  output logic                  buf_we,
  output logic [BUF_ADDR_W-1:0] buf_addr,
  output logic [7:0]            buf_wdata,
  output logic                  rx_ready,
  output logic [BUF_ADDR_W:0]   rx_nbytes,
  output logic                  crc_ok,
  output logic [7:0]            drop_cnt
);

  localparam int CW = BUF_ADDR_W + 1;
  localparam logic [BUF_ADDR_W:0] BUF_DEPTH = CW'(1 << BUF_ADDR_W);
  localparam logic [BUF_ADDR_W:0] MIN_CNT   = CW'(MIN_FRAME);
  localparam logic [BUF_ADDR_W:0] MAC_LEN   = CW'(MAC_BYTES);
  localparam logic [BUF_ADDR_W:0] CNT_ONE   = CW'(1);

  rx_state_t           state;
  logic                phase;
  logic [3:0]          low_nib;
  logic [BUF_ADDR_W:0] byte_cnt;
  logic [31:0]         crc_reg;
  logic                own_match;
  logic                bcast_match;

  logic [7:0]  cur_byte;
  logic [31:0] crc_next;
  logic [7:0]  mac_byte;
  logic        in_dest;
  logic        own_hit;
  logic        bcast_hit;
  logic        dest_fail;
  logic        overflow;

  assign cur_byte = {rx_data, low_nib};

  iob_eth_crc32 u_crc (
    .crc_in  (crc_reg),
    .data    (cur_byte),
    .crc_out (crc_next)
  );

  // Own-MAC byte expected at the current destination position, MSB byte first.
  always_comb begin
    mac_byte = 8'h00;
    for (int i = 0; i < MAC_BYTES; i++) begin
      if (byte_cnt == CW'(i)) mac_byte = mac_addr[47-8*i -: 8];
    end
  end

  assign in_dest   = (byte_cnt < MAC_LEN);
  assign own_hit   = own_match & (cur_byte == mac_byte);
  assign bcast_hit = bcast_match & (cur_byte == BCAST_BYTE);
  assign dest_fail = in_dest & ~own_hit & ~bcast_hit;
  assign overflow  = (byte_cnt == BUF_DEPTH);

  // Single receive FSM; every output is registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      phase       <= 1'b0;
      low_nib     <= 4'h0;
      byte_cnt    <= '0;
      crc_reg     <= CRC_INIT;
      own_match   <= 1'b0;
      bcast_match <= 1'b0;
      buf_we      <= 1'b0;
      buf_addr    <= '0;
      buf_wdata   <= 8'h00;
      rx_ready    <= 1'b0;
      rx_nbytes   <= '0;
      crc_ok      <= 1'b0;
      drop_cnt    <= 8'h00;
    end else begin
      buf_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rx_dv) state <= (rx_data == PREAMBLE_NIB) ? ST_PRE : ST_DROP;
        end

        ST_PRE: begin
          if (!rx_dv) begin
            state <= ST_IDLE;
          end else if (rx_data == SFD_NIB) begin
            state       <= ST_DATA;
            phase       <= 1'b0;
            byte_cnt    <= '0;
            crc_reg     <= CRC_INIT;
            own_match   <= 1'b1;
            bcast_match <= 1'b1;
          end else if (rx_data != PREAMBLE_NIB) begin
            state    <= ST_DROP;
            drop_cnt <= sat_inc8(drop_cnt);
          end
        end

        ST_DATA: begin
          if (!rx_dv) begin
            if (phase || (byte_cnt < MIN_CNT)) begin
              state    <= ST_IDLE;
              drop_cnt <= sat_inc8(drop_cnt);
            end else begin
              state     <= ST_DONE;
              rx_ready  <= 1'b1;
              rx_nbytes <= byte_cnt;
              crc_ok    <= (crc_reg == CRC_RESIDUE);
            end
          end else if (!phase) begin
            low_nib <= rx_data;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (overflow || dest_fail) begin
              state    <= ST_DROP;
              drop_cnt <= sat_inc8(drop_cnt);
            end else begin
              buf_we    <= 1'b1;
              buf_addr  <= byte_cnt[BUF_ADDR_W-1:0];
              buf_wdata <= cur_byte;
              byte_cnt  <= byte_cnt + CNT_ONE;
              crc_reg   <= crc_next;
              if (in_dest) begin
                own_match   <= own_hit;
                bcast_match <= bcast_hit;
              end
            end
          end
        end

        // Going to DROP when the line is busy avoids locking onto mid-frame data.
        ST_DONE: begin
          if (rcv_ack) begin
            rx_ready <= 1'b0;
            crc_ok   <= 1'b0;
            state    <= rx_dv ? ST_DROP : ST_IDLE;
          end
        end

        ST_DROP: begin
          if (!rx_dv) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iob_eth_rx_mii.sv
// Self-checking bench for iob_eth_rx_mii: directed frames plus randomized
// frames checked against a frame-level reference model.
module tb_iob_eth_rx_mii;

  localparam int AW   = 11;
  localparam int AW_S = 6;
  localparam logic [47:0] OWN_MAC = 48'h01606E11020F;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] rx_data = 4'h0;
  logic dv = 1'b0;
  logic sel_small = 1'b0;
  logic rcv_ack = 1'b0;
  logic rx_dv_m, rx_dv_s, rcv_ack_s;
  logic [47:0] mac_addr;

  logic          buf_we, rx_ready, crc_ok;
  logic [AW-1:0] buf_addr;
  logic [7:0]    buf_wdata, drop_cnt;
  logic [AW:0]   rx_nbytes;

  logic            buf_we_s, rx_ready_s, crc_ok_s;
  logic [AW_S-1:0] buf_addr_s;
  logic [7:0]      buf_wdata_s, drop_cnt_s;
  logic [AW_S:0]   rx_nbytes_s;

  assign rx_dv_m   = dv & ~sel_small;
  assign rx_dv_s   = dv & sel_small;
  assign rcv_ack_s = 1'b0;
  assign mac_addr  = OWN_MAC;

  always #5 clk = ~clk;

  iob_eth_rx_mii #(.BUF_ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv_m),
    .mac_addr(mac_addr), .rcv_ack(rcv_ack), .buf_we(buf_we),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .rx_ready(rx_ready),
    .rx_nbytes(rx_nbytes), .crc_ok(crc_ok), .drop_cnt(drop_cnt)
  );

  iob_eth_rx_mii #(.BUF_ADDR_W(AW_S)) dut_small (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_dv(rx_dv_s),
    .mac_addr(mac_addr), .rcv_ack(rcv_ack_s), .buf_we(buf_we_s),
    .buf_addr(buf_addr_s), .buf_wdata(buf_wdata_s), .rx_ready(rx_ready_s),
    .rx_nbytes(rx_nbytes_s), .crc_ok(crc_ok_s), .drop_cnt(drop_cnt_s)
  );

  logic [AW-1:0]   wa_q[$];
  logic [7:0]      wd_q[$];
  logic [AW_S-1:0] wa_s_q[$];

  // Capture every buffer write of both instances, away from the active edge.
  always @(negedge clk) begin
    if (buf_we) begin
      wa_q.push_back(buf_addr);
      wd_q.push_back(buf_wdata);
    end
    if (buf_we_s) wa_s_q.push_back(buf_addr_s);
  end

  int total = 0;
  int bad   = 0;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] crc32_std(input bq_t d, input int n);
    logic [31:0] r = 32'hFFFFFFFF;
    logic fb;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) begin
        fb = r[0] ^ d[i][k];
        r  = r >> 1;
        if (fb) r = r ^ 32'hEDB88320;
      end
    end
    return ~r;
  endfunction

  function automatic bq_t build_frame(input logic [47:0] dest, input int plen, input bit rnd);
    bq_t f;
    logic [47:0] src = OWN_MAC;
    logic [31:0] c;
    for (int i = 0; i < 6; i++) f.push_back(dest[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(src[47-8*i -: 8]);
    f.push_back(8'h08);
    f.push_back(8'h00);
    for (int i = 0; i < plen; i++) f.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(i + 1));
    c = crc32_std(f, f.size());
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    return f;
  endfunction

  function automatic bit fcs_good(input bq_t f);
    int n = f.size();
    return {f[n-1], f[n-2], f[n-3], f[n-4]} == crc32_std(f, n - 4);
  endfunction

  function automatic bit dest_ok(input bq_t f);
    logic [47:0] m = OWN_MAC;
    bit own = 1'b1;
    bit bc  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (f[i] != m[47-8*i -: 8]) own = 1'b0;
      if (f[i] != 8'hFF) bc = 1'b0;
    end
    return own | bc;
  endfunction

  task automatic drive_nib(input logic [3:0] n, input bit ack);
    @(negedge clk);
    dv      = 1'b1;
    rx_data = n;
    rcv_ack = ack;
  endtask

  task automatic apply_stimulus(input bq_t f, input bit odd, input int ack_at);
    int nib = 0;
    for (int i = 0; i < 31; i++) drive_nib(4'h5, 1'b0);
    drive_nib(4'hD, 1'b0);
    foreach (f[i]) begin
      drive_nib(f[i][3:0], nib == ack_at);
      nib++;
      drive_nib(f[i][7:4], nib == ack_at);
      nib++;
    end
    if (odd) drive_nib(4'h3, 1'b0);
    @(negedge clk);
    dv      = 1'b0;
    rx_data = 4'h0;
    rcv_ack = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic ack_frame(input string tag);
    @(negedge clk);
    rcv_ack = 1'b1;
    @(negedge clk);
    rcv_ack = 1'b0;
    @(negedge clk);
    check_output({tag, "_ack_ready"}, 64'(rx_ready), 64'd0);
    check_output({tag, "_ack_crc"}, 64'(crc_ok), 64'd0);
  endtask

  task automatic check_writes(input string tag, input bq_t f, input int base, input int n_exp);
    check_output({tag, "_wcount"}, 64'(wa_q.size() - base), 64'(n_exp));
    if (wa_q.size() - base == n_exp) begin
      for (int i = 0; i < n_exp; i++) begin
        check_output({tag, "_waddr"}, 64'(wa_q[base+i]), 64'(i));
        check_output({tag, "_wdata"}, 64'(wd_q[base+i]), 64'(f[i]));
      end
    end
  endtask

  bq_t fa, f;
  int  base, exp_drop, plen, kind, pos, wr_mark;
  bit  odd, acc;

  initial begin
    $display("[TB] start");
    exp_drop = 0;
    fa = build_frame(OWN_MAC, 46, 1'b0);

    #2;
    check_output("rst_we", 64'(buf_we), 64'd0);
    check_output("rst_ready", 64'(rx_ready), 64'd0);
    check_output("rst_nbytes", 64'(rx_nbytes), 64'd0);
    check_output("rst_crc", 64'(crc_ok), 64'd0);
    check_output("rst_drop", 64'(drop_cnt), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    base = wa_q.size();
    apply_stimulus(fa, 1'b0, -1);
    check_writes("fa", fa, base, 64);
    check_output("fa_ready", 64'(rx_ready), 64'd1);
    check_output("fa_nbytes", 64'(rx_nbytes), 64'd64);
    check_output("fa_crc", 64'(crc_ok), 64'd1);
    check_output("fa_drop", 64'(drop_cnt), 64'd0);
    ack_frame("fa");

    f = fa;
    f[24] = f[24] ^ 8'h01;
    apply_stimulus(f, 1'b0, -1);
    check_output("bad_ready", 64'(rx_ready), 64'd1);
    check_output("bad_nbytes", 64'(rx_nbytes), 64'd64);
    check_output("bad_crc", 64'(crc_ok), 64'd0);
    ack_frame("bad");

    f = build_frame(48'hFFFFFFFFFFFF, 46, 1'b0);
    apply_stimulus(f, 1'b0, -1);
    check_output("bc_ready", 64'(rx_ready), 64'd1);
    check_output("bc_crc", 64'(crc_ok), 64'd1);
    ack_frame("bc");

    f = build_frame(48'h01606E110210, 46, 1'b0);
    apply_stimulus(f, 1'b0, -1);
    exp_drop++;
    check_output("mis_ready", 64'(rx_ready), 64'd0);
    check_output("mis_drop", 64'(drop_cnt), 64'(exp_drop));

    f = build_frame(OWN_MAC, 42, 1'b0);
    apply_stimulus(f, 1'b0, -1);
    exp_drop++;
    check_output("runt_ready", 64'(rx_ready), 64'd0);
    check_output("runt_drop", 64'(drop_cnt), 64'(exp_drop));

    apply_stimulus(fa, 1'b1, -1);
    exp_drop++;
    check_output("odd_ready", 64'(rx_ready), 64'd0);
    check_output("odd_drop", 64'(drop_cnt), 64'(exp_drop));

    apply_stimulus(fa, 1'b0, -1);
    check_output("hold1_ready", 64'(rx_ready), 64'd1);
    base = wa_q.size();
    apply_stimulus(fa, 1'b0, -1);
    check_output("hold2_writes", 64'(wa_q.size() - base), 64'd0);
    check_output("hold2_ready", 64'(rx_ready), 64'd1);
    check_output("hold2_nbytes", 64'(rx_nbytes), 64'd64);
    check_output("hold2_drop", 64'(drop_cnt), 64'(exp_drop));
    base = wa_q.size();
    apply_stimulus(fa, 1'b0, 40);
    check_output("midack_writes", 64'(wa_q.size() - base), 64'd0);
    check_output("midack_ready", 64'(rx_ready), 64'd0);
    check_output("midack_drop", 64'(drop_cnt), 64'(exp_drop));
    base = wa_q.size();
    apply_stimulus(fa, 1'b0, -1);
    check_writes("after", fa, base, 64);
    check_output("after_ready", 64'(rx_ready), 64'd1);
    check_output("after_crc", 64'(crc_ok), 64'd1);
    ack_frame("after");

    for (int it = 0; it < 14; it++) begin
      kind = $urandom_range(0, 5);
      plen = (kind == 3) ? $urandom_range(20, 41) : $urandom_range(46, 80);
      case (kind)
        1:       f = build_frame(48'hFFFFFFFFFFFF, plen, 1'b1);
        5:       f = build_frame({$urandom, 16'($urandom)}, plen, 1'b1);
        default: f = build_frame(OWN_MAC, plen, 1'b1);
      endcase
      if (kind == 2) begin
        pos = $urandom_range(14, f.size() - 5);
        f[pos] = f[pos] ^ 8'($urandom_range(1, 255));
      end
      odd = (kind == 4);
      acc = dest_ok(f) && !odd && (f.size() >= 64);
      if (!acc) exp_drop++;
      base = wa_q.size();
      apply_stimulus(f, odd, -1);
      check_output("rnd_ready", 64'(rx_ready), 64'(acc));
      check_output("rnd_drop", 64'(drop_cnt), 64'(exp_drop));
      if (acc) begin
        check_output("rnd_nbytes", 64'(rx_nbytes), 64'(f.size()));
        check_output("rnd_crc", 64'(crc_ok), 64'(fcs_good(f)));
        check_writes("rnd", f, base, f.size());
        ack_frame("rnd");
      end
    end

    @(negedge clk);
    sel_small = 1'b1;
    f = build_frame(OWN_MAC, 52, 1'b0);
    apply_stimulus(f, 1'b0, -1);
    check_output("ovf_wcount", 64'(wa_s_q.size()), 64'd64);
    if (wa_s_q.size() == 64) begin
      for (int i = 0; i < 64; i++) check_output("ovf_waddr", 64'(wa_s_q[i]), 64'(i));
    end
    check_output("ovf_ready", 64'(rx_ready_s), 64'd0);
    check_output("ovf_drop", 64'(drop_cnt_s), 64'd1);
    sel_small = 1'b0;

    wr_mark = 0;
    fork
      apply_stimulus(fa, 1'b0, -1);
      begin
        repeat (150) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("arst_we", 64'(buf_we), 64'd0);
        check_output("arst_addr", 64'(buf_addr), 64'd0);
        check_output("arst_wdata", 64'(buf_wdata), 64'd0);
        check_output("arst_ready", 64'(rx_ready), 64'd0);
        check_output("arst_nbytes", 64'(rx_nbytes), 64'd0);
        check_output("arst_crc", 64'(crc_ok), 64'd0);
        check_output("arst_drop", 64'(drop_cnt), 64'd0);
        wr_mark = wa_q.size();
        @(negedge clk);
        rst = 1'b1;
      end
    join
    check_output("post_rst_ready", 64'(rx_ready), 64'd0);
    check_output("post_rst_writes", 64'(wa_q.size() - wr_mark), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
